// File: rtl/fetch_pkg.sv
// Shared IF-stage definitions: reset defaults, PC increment and the IF/ID bundle
// that decode consumes.
package fetch_pkg;

  localparam logic [31:0] RESET_PC_DEFAULT  = 32'h0040_0000;
  localparam logic [31:0] NOP_INSTR_DEFAULT = 32'h0000_0000;
  localparam logic [31:0] PC_INC            = 32'd4;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] pcn;
    logic [31:0] ins;
    logic        valid;
  } fd_reg_t;

endpackage

// File: rtl/fetch_pc_gen.sv
// PC register with priority next-PC select (stall > redirect > +4), word-aligned
// redirect targets and a registered misaligned-target pulse.
module fetch_pc_gen
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        stall_in,
  input  logic        redirect_in,
  input  logic [31:0] redirect_target_in,
  output logic [31:0] pc_out,
  output logic [31:0] pc_plus4_out,
  output logic        misalign_out
);

  logic [31:0] r_pc;
  logic        r_misalign;
  logic [31:0] w_pc_plus4;
  logic [31:0] w_target_aligned;
  logic        w_redirect_taken;

  assign w_pc_plus4       = r_pc + PC_INC;
  assign w_target_aligned = {redirect_target_in[31:2], 2'b00};
  // A redirect that coincides with a stall is dropped; decode re-presents it.
  assign w_redirect_taken = redirect_in && !stall_in;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_pc       <= RESET_PC;
      r_misalign <= 1'b0;
    end else begin
      r_misalign <= w_redirect_taken && (redirect_target_in[1:0] != 2'b00);
      if (!stall_in) begin
        if (redirect_in) begin
          r_pc <= w_target_aligned;
        end else begin
          r_pc <= w_pc_plus4;
        end
      end
    end
  end

  assign pc_out       = r_pc;
  assign pc_plus4_out = w_pc_plus4;
  assign misalign_out = r_misalign;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage and IF/ID register. Define FETCH_DELAY_SLOT_EN to keep the
// instruction after a taken redirect (MIPS delay slot) instead of squashing it.
module fetch_stage
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = RESET_PC_DEFAULT,
  parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEFAULT
) (
  input  logic        clock,
  input  logic        reset,
  output logic [31:0] imem_addr_out,
  input  logic [31:0] imem_data_in,
  input  logic        stall_in,
  input  logic        redirect_in,
  input  logic [31:0] redirect_target_in,
  output logic [31:0] fd_pc_out,
  output logic [31:0] fd_pcn_out,
  output logic [31:0] fd_ins_out,
  output logic        fd_valid_out,
  output logic        misalign_out,
  output logic [31:0] fetch_count_out
);

  logic [31:0] w_pc;
  logic [31:0] w_pc_plus4;
  fd_reg_t     r_fd;
  logic [31:0] r_fetch_count;

  fetch_pc_gen #(
    .RESET_PC (RESET_PC)
  ) u_pc_gen (
    .clock              (clock),
    .reset              (reset),
    .stall_in           (stall_in),
    .redirect_in        (redirect_in),
    .redirect_target_in (redirect_target_in),
    .pc_out             (w_pc),
    .pc_plus4_out       (w_pc_plus4),
    .misalign_out       (misalign_out)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_fd.pc       <= RESET_PC;
      r_fd.pcn      <= RESET_PC + PC_INC;
      r_fd.ins      <= NOP_INSTR;
      r_fd.valid    <= 1'b0;
      r_fetch_count <= 32'd0;
    end else if (!stall_in) begin
      r_fd.pc  <= w_pc;
      r_fd.pcn <= w_pc_plus4;
      if (redirect_in) begin
`ifdef FETCH_DELAY_SLOT_EN
        r_fd.ins      <= imem_data_in;
        r_fd.valid    <= 1'b1;
        r_fetch_count <= r_fetch_count + 32'd1;
`else
        // Squash the fall-through instruction; a bubble never carries a stale word.
        r_fd.ins      <= NOP_INSTR;
        r_fd.valid    <= 1'b0;
`endif
      end else begin
        r_fd.ins      <= imem_data_in;
        r_fd.valid    <= 1'b1;
        r_fetch_count <= r_fetch_count + 32'd1;
      end
    end
  end

  assign imem_addr_out   = w_pc;
  assign fd_pc_out       = r_fd.pc;
  assign fd_pcn_out      = r_fd.pcn;
  assign fd_ins_out      = r_fd.ins;
  assign fd_valid_out    = r_fd.valid;
  assign fetch_count_out = r_fetch_count;

endmodule
